// File: rtl/job_encoder.sv
// -----------------------------------------------------------------------------
// job_encoder
//   Host-side transmitter for the job decode path. Accepts per-host job
//   requests, allocates the lowest free tag of the requesting host from a
//   per-host tag bitmap, and issues one packed 128-bit info word as a
//   single-cycle strobe. Completions return tags to the free pool.
//
//   State table
//      state    | meaning
//      ---------+-----------------------------------------------------------
//      ST_IDLE  | ready for a request; accept latches host/meta/tag
//      ST_ISSUE | o_info_req high for this one cycle, no new request taken
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req_valid      job request valid
//   o_req_ready      request accepted when valid && ready (combinational)
//   i_req_host_id    requesting host
//   i_req_meta       metadata; plane id in the low PLANE_ID_BIT_WIDTH bits
//   i_cpl_valid      completion strobe, frees one tag
//   i_cpl_host_id    completing host
//   i_cpl_tag        completing tag
//   o_info           packed info word {1'b1, tag, host_id, meta}
//   o_info_req       one-cycle strobe qualifying o_info
//   o_tag            tag of the word being issued
//   o_full           bit h = every tag of host h outstanding
//   o_cpl_err        one-cycle pulse: completion for a tag not outstanding
// -----------------------------------------------------------------------------

`ifndef MAX_HOST_NUMBER
`define MAX_HOST_NUMBER 4
`endif
`ifndef MAX_PLANE_NUMBER
`define MAX_PLANE_NUMBER 8
`endif
`ifndef NO_OF_TAG
`define NO_OF_TAG 16
`endif

module job_encoder #(
   parameter int MAX_HOST_NUMBER     = `MAX_HOST_NUMBER,
   parameter int MAX_PLANE_NUMBER    = `MAX_PLANE_NUMBER,
   parameter int NO_OF_TAG           = `NO_OF_TAG,
   parameter int HOST_ID_BIT_WIDTH   = $clog2(MAX_HOST_NUMBER),
   parameter int PLANE_ID_BIT_WIDTH  = $clog2(MAX_PLANE_NUMBER),
   parameter int TAG_BIT_WIDTH       = $clog2(NO_OF_TAG),
   parameter int INFO_DATA_BIT_WIDTH = 128,
   parameter int META_DATA_BIT_WIDTH = INFO_DATA_BIT_WIDTH - TAG_BIT_WIDTH - HOST_ID_BIT_WIDTH - 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_req_valid,
   output logic                           o_req_ready,
   input  logic [HOST_ID_BIT_WIDTH-1:0]   i_req_host_id,
   input  logic [META_DATA_BIT_WIDTH-1:0] i_req_meta,
   input  logic                           i_cpl_valid,
   input  logic [HOST_ID_BIT_WIDTH-1:0]   i_cpl_host_id,
   input  logic [TAG_BIT_WIDTH-1:0]       i_cpl_tag,
   output logic [INFO_DATA_BIT_WIDTH-1:0] o_info,
   output logic                           o_info_req,
   output logic [TAG_BIT_WIDTH-1:0]       o_tag,
   output logic [MAX_HOST_NUMBER-1:0]     o_full,
   output logic                           o_cpl_err
);

   // The plane id rides inside the metadata field, so it must fit there.
   if (PLANE_ID_BIT_WIDTH > META_DATA_BIT_WIDTH) begin : g_bad_cfg
      $error("job_encoder: plane id does not fit in the metadata field");
   end

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_e;

   state_e                           state_q, state_d;

   logic [NO_OF_TAG-1:0]             bitmap_q [MAX_HOST_NUMBER];
   logic [NO_OF_TAG-1:0]             bitmap_d [MAX_HOST_NUMBER];
   logic [MAX_HOST_NUMBER-1:0]       full_q, full_d;

   logic [INFO_DATA_BIT_WIDTH-1:0]   info_q, info_d;
   logic [TAG_BIT_WIDTH-1:0]         tag_q, tag_d;
   logic                             info_req_q, info_req_d;
   logic                             cpl_err_q, cpl_err_d;

   logic                             req_host_ok;
   logic [NO_OF_TAG-1:0]             req_row;
   logic [TAG_BIT_WIDTH-1:0]         alloc_tag;
   logic                             accept;
   logic                             cpl_hit;

   // ---------------------------------------------------------------------------
   // Request side: bitmap row of the requesting host and lowest free tag.
   // An out-of-range host sees an all-ones row, so it is never ready.
   // ---------------------------------------------------------------------------
   assign req_host_ok = 32'(i_req_host_id) < MAX_HOST_NUMBER;

   always_comb begin
      req_row = '1;
      for (int h = 0; h < MAX_HOST_NUMBER; h++) begin
         if (32'(i_req_host_id) == h) req_row = bitmap_q[h];
      end
   end

   always_comb begin
      alloc_tag = '0;
      for (int t = NO_OF_TAG - 1; t >= 0; t--) begin
         if (!req_row[t]) alloc_tag = TAG_BIT_WIDTH'(t);
      end
   end

   // A full row is exactly what full_q holds for that host, but using the
   // row directly keeps ready free of the out-of-range index case.
   assign o_req_ready = (state_q == ST_IDLE) && req_host_ok && !(&req_row);
   assign accept      = i_req_valid && o_req_ready;

   // ---------------------------------------------------------------------------
   // Completion side: a hit only when the addressed bit is currently set.
   // ---------------------------------------------------------------------------
   always_comb begin
      cpl_hit = 1'b0;
      for (int h = 0; h < MAX_HOST_NUMBER; h++) begin
         if (i_cpl_valid && (32'(i_cpl_host_id) == h) && bitmap_q[h][i_cpl_tag])
            cpl_hit = 1'b1;
      end
   end

   assign cpl_err_d = i_cpl_valid && !cpl_hit;

   // Allocation was taken from bitmap_q, so a tag freed this cycle is not
   // handed out until the next one. The allocated bit is always clear in
   // bitmap_q and a hit always clears a set bit, so the two never collide.
   always_comb begin
      full_d = '0;
      for (int h = 0; h < MAX_HOST_NUMBER; h++) begin
         bitmap_d[h] = bitmap_q[h];
         if (cpl_hit && (32'(i_cpl_host_id) == h)) bitmap_d[h][i_cpl_tag] = 1'b0;
         if (accept && (32'(i_req_host_id) == h))  bitmap_d[h][alloc_tag] = 1'b1;
         full_d[h] = &bitmap_d[h];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int h = 0; h < MAX_HOST_NUMBER; h++) bitmap_q[h] <= '0;
         full_q    <= '0;
         cpl_err_q <= 1'b0;
      end else begin
         for (int h = 0; h < MAX_HOST_NUMBER; h++) bitmap_q[h] <= bitmap_d[h];
         full_q    <= full_d;
         cpl_err_q <= cpl_err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs. The issue registers load on the accepting edge so that the
   // strobe, word and tag are all valid throughout the single ISSUE cycle.
   // Outside ISSUE the word and tag hold their last value.
   // ---------------------------------------------------------------------------
   always_comb begin
      info_d     = info_q;
      tag_d      = tag_q;
      info_req_d = 1'b0;
      if ((state_q == ST_IDLE) && (state_d == ST_ISSUE)) begin
         info_d     = {1'b1, alloc_tag, i_req_host_id, i_req_meta};
         tag_d      = alloc_tag;
         info_req_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         info_q     <= '0;
         tag_q      <= '0;
         info_req_q <= 1'b0;
      end else begin
         info_q     <= info_d;
         tag_q      <= tag_d;
         info_req_q <= info_req_d;
      end
   end

   assign o_info     = info_q;
   assign o_tag      = tag_q;
   assign o_info_req = info_req_q;
   assign o_full     = full_q;
   assign o_cpl_err  = cpl_err_q;

endmodule
